// File: rtl/aes_sw_pkg.sv
// Shared types and handshake codes for the Nios II PIO <-> AES bridge.
package aes_sw_pkg;

  localparam int unsigned WORDS = 4;

  typedef enum logic [2:0] {
    WR_WAIT,
    WR_ACK,
    BUSY,
    RD_WAIT,
    RD_ACK
  } bridge_state_t;

  localparam logic [1:0] CMD_IDLE  = 2'b00;
  localparam logic [1:0] CMD_WRITE = 2'b01;
  localparam logic [1:0] CMD_READ  = 2'b10;
  localparam logic [1:0] CMD_ABORT = 2'b11;

  localparam logic [1:0] STS_NONE         = 2'b00;
  localparam logic [1:0] STS_WR_ACK       = 2'b01;
  localparam logic [1:0] STS_RESULT_READY = 2'b10;
  localparam logic [1:0] STS_DATA_VALID   = 2'b11;

endpackage

// File: rtl/aes_sw_bridge.sv
// Word-serial handshake bridge: assembles ciphertext/key for the AES core
// from software writes and returns the 128-bit result as four read words.
module aes_sw_bridge
  import aes_sw_pkg::*;
#(
  parameter int unsigned WORDS = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [1:0]            to_hw_sig,
  input  logic [31:0]           to_hw_port,
  output logic [1:0]            to_sw_sig,
  output logic [31:0]           to_sw_port,
  output logic [32*WORDS-1:0]   msg_en,
  output logic [32*WORDS-1:0]   key,
  output logic                  io_ready,
  input  logic [32*WORDS-1:0]   msg_de,
  input  logic                  aes_ready
);

  bridge_state_t state, state_d;
  logic [2:0]   wcnt, wcnt_d;
  logic [1:0]   rcnt, rcnt_d;
  logic [127:0] result, result_d;
  logic [127:0] msg_en_d, key_d;
  logic [1:0]   sig_d;
  logic [31:0]  port_d;
  logic         io_ready_d;
  logic [6:0]   wsel, rsel;

  // Word 0 maps to the most significant 32 bits of each operand.
  assign wsel = 7'd127 - {wcnt[1:0], 5'd0};
  assign rsel = 7'd127 - {rcnt, 5'd0};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= WR_WAIT;
      wcnt       <= '0;
      rcnt       <= '0;
      result     <= '0;
      msg_en     <= '0;
      key        <= '0;
      to_sw_sig  <= STS_NONE;
      to_sw_port <= '0;
      io_ready   <= 1'b0;
    end else begin
      state      <= state_d;
      wcnt       <= wcnt_d;
      rcnt       <= rcnt_d;
      result     <= result_d;
      msg_en     <= msg_en_d;
      key        <= key_d;
      to_sw_sig  <= sig_d;
      to_sw_port <= port_d;
      io_ready   <= io_ready_d;
    end
  end

  always_comb begin
    state_d    = state;
    wcnt_d     = wcnt;
    rcnt_d     = rcnt;
    result_d   = result;
    msg_en_d   = msg_en;
    key_d      = key;
    sig_d      = to_sw_sig;
    port_d     = to_sw_port;
    io_ready_d = io_ready;

    // ABORT wins in every state; operand and result registers are kept.
    if (to_hw_sig == CMD_ABORT) begin
      state_d    = WR_WAIT;
      wcnt_d     = '0;
      rcnt_d     = '0;
      io_ready_d = 1'b0;
      sig_d      = STS_NONE;
      port_d     = '0;
    end else begin
      case (state)
        WR_WAIT: begin
          if (to_hw_sig == CMD_WRITE) begin
            if (wcnt[2]) key_d[wsel -: 32]    = to_hw_port;
            else         msg_en_d[wsel -: 32] = to_hw_port;
            sig_d   = STS_WR_ACK;
            state_d = WR_ACK;
          end
        end
        WR_ACK: begin
          if (to_hw_sig == CMD_IDLE) begin
            sig_d = STS_NONE;
            if (wcnt == 3'd7) begin
              wcnt_d     = '0;
              io_ready_d = 1'b1;
              state_d    = BUSY;
            end else begin
              wcnt_d  = wcnt + 3'd1;
              state_d = WR_WAIT;
            end
          end
        end
        BUSY: begin
          if (aes_ready) begin
            result_d   = msg_de;
            io_ready_d = 1'b0;
            sig_d      = STS_RESULT_READY;
            state_d    = RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (to_hw_sig == CMD_READ) begin
            port_d  = result[rsel -: 32];
            sig_d   = STS_DATA_VALID;
            state_d = RD_ACK;
          end
        end
        RD_ACK: begin
          if (to_hw_sig == CMD_IDLE) begin
            port_d = '0;
            if (rcnt == 2'd3) begin
              rcnt_d  = '0;
              sig_d   = STS_NONE;
              state_d = WR_WAIT;
            end else begin
              rcnt_d  = rcnt + 2'd1;
              sig_d   = STS_RESULT_READY;
              state_d = RD_WAIT;
            end
          end
        end
        default: state_d = WR_WAIT;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_sw_bridge.sv
// Scoreboard bench for aes_sw_bridge: drives the SW handshake and an AES stub.
module tb_aes_sw_bridge;
  import aes_sw_pkg::*;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [1:0]   to_hw_sig;
  logic [31:0]  to_hw_port;
  logic [1:0]   to_sw_sig;
  logic [31:0]  to_sw_port;
  logic [127:0] msg_en, key, msg_de;
  logic         io_ready, aes_ready;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [31:0] sb[$];

  aes_sw_bridge #(.WORDS(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .to_hw_sig(to_hw_sig), .to_hw_port(to_hw_port),
    .to_sw_sig(to_sw_sig), .to_sw_port(to_sw_port),
    .msg_en(msg_en), .key(key), .io_ready(io_ready),
    .msg_de(msg_de), .aes_ready(aes_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_word(input logic [31:0] d);
    to_hw_sig  = CMD_WRITE;
    to_hw_port = d;
    tick();
    check("wr_ack", {126'd0, to_sw_sig}, {126'd0, STS_WR_ACK});
    to_hw_sig = CMD_IDLE;
    tick();
    check("wr_ack_clr", {126'd0, to_sw_sig}, {126'd0, STS_NONE});
  endtask

  task automatic write8(input logic [255:0] w);
    logic [255:0] v;
    v = w;
    for (int i = 0; i < 8; i++) wr_word(v[255-32*i -: 32]);
    check("msg_en", msg_en, v[255:128]);
    check("key", key, v[127:0]);
    check("io_ready_up", {127'd0, io_ready}, 128'd1);
  endtask

  task automatic push_result(input logic [127:0] r);
    logic [127:0] v;
    v = r;
    for (int i = 0; i < 4; i++) sb.push_back(v[127-32*i -: 32]);
  endtask

  task automatic rd_word();
    logic [31:0] e;
    for (int i = 0; i < 50 && to_sw_sig != STS_RESULT_READY; i++) tick();
    check("rr_wait", {126'd0, to_sw_sig}, {126'd0, STS_RESULT_READY});
    to_hw_sig = CMD_READ;
    tick();
    check("dv_sig", {126'd0, to_sw_sig}, {126'd0, STS_DATA_VALID});
    if (sb.size() == 0) check("sb_empty", 128'd1, 128'd0);
    else begin
      e = sb.pop_front();
      check("rd_data", {96'd0, to_sw_port}, {96'd0, e});
    end
    to_hw_sig = CMD_IDLE;
    tick();
    check("rd_port_clr", {96'd0, to_sw_port}, 128'd0);
  endtask

  task automatic read4();
    for (int i = 0; i < 4; i++) rd_word();
    check("rd_done_sig", {126'd0, to_sw_sig}, {126'd0, STS_NONE});
  endtask

  initial begin
    logic [255:0] ops;
    logic [127:0] res, r2;
    reset_n    = 1'b0;
    to_hw_sig  = CMD_IDLE;
    to_hw_port = '0;
    msg_de     = '0;
    aes_ready  = 1'b0;
    tick();
    check("rst_sig", {126'd0, to_sw_sig}, 128'd0);
    check("rst_port", {96'd0, to_sw_port}, 128'd0);
    check("rst_msg", msg_en, 128'd0);
    check("rst_key", key, 128'd0);
    check("rst_io", {127'd0, io_ready}, 128'd0);
    reset_n = 1'b1;
    tick();

    // Full transaction, with READ in WR_WAIT and stray aes_ready ignored.
    to_hw_sig = CMD_READ;
    tick();
    check("read_in_wr", {126'd0, to_sw_sig}, 128'd0);
    to_hw_sig = CMD_IDLE;
    aes_ready = 1'b1;
    msg_de    = 128'hdead_0000_dead_0000_dead_0000_dead_0000;
    tick();
    aes_ready = 1'b0;
    check("stray_aes", {126'd0, to_sw_sig}, 128'd0);
    ops = 256'h69c4e0d8_6a7b0430_d8cdb780_70b4c55a_00010203_04050607_08090a0b_0c0d0e0f;
    write8(ops);
    res = 128'h00112233_44556677_8899aabb_ccddeeff;
    for (int i = 0; i < 20; i++) tick();
    check("busy_io", {127'd0, io_ready}, 128'd1);
    msg_de    = res;
    aes_ready = 1'b1;
    push_result(res);
    tick();
    aes_ready = 1'b0;
    msg_de    = '1;
    check("io_fall", {127'd0, io_ready}, 128'd0);
    check("rr_sig", {126'd0, to_sw_sig}, {126'd0, STS_RESULT_READY});
    read4();

    // Held WRITE stores once; WRITE during BUSY is ignored.
    to_hw_sig  = CMD_WRITE;
    to_hw_port = 32'h1111_2222;
    for (int i = 0; i < 10; i++) begin
      if (i == 5) to_hw_port = 32'h3333_4444;
      tick();
    end
    check("held_ack", {126'd0, to_sw_sig}, {126'd0, STS_WR_ACK});
    check("held_word", {96'd0, msg_en[127:96]}, 128'h1111_2222);
    to_hw_sig = CMD_IDLE;
    tick();
    for (int i = 1; i < 8; i++) wr_word(32'hA000_0000 + 32'(i));
    check("held_msg", msg_en, 128'h11112222_a0000001_a0000002_a0000003);
    check("held_key", key, 128'ha0000004_a0000005_a0000006_a0000007);
    to_hw_sig  = CMD_WRITE;
    to_hw_port = 32'hdeadbeef;
    tick(); tick(); tick();
    check("busy_wr_msg", msg_en, 128'h11112222_a0000001_a0000002_a0000003);
    check("busy_wr_key", key, 128'ha0000004_a0000005_a0000006_a0000007);
    check("busy_wr_io", {127'd0, io_ready}, 128'd1);
    check("busy_wr_sig", {126'd0, to_sw_sig}, 128'd0);
    to_hw_sig = CMD_IDLE;
    r2 = 128'hcafef00d_01234567_89abcdef_fedcba98;
    msg_de = r2;
    aes_ready = 1'b1;
    push_result(r2);
    tick();
    aes_ready = 1'b0;
    read4();

    // ABORT after five words, then a fresh sequence.
    for (int i = 0; i < 5; i++) wr_word(32'h5500_0000 + 32'(i));
    to_hw_sig = CMD_ABORT;
    tick();
    check("abort_sig", {126'd0, to_sw_sig}, 128'd0);
    check("abort_io", {127'd0, io_ready}, 128'd0);
    to_hw_sig = CMD_IDLE;
    tick();
    ops = 256'h10000000_20000000_30000000_40000000_50000000_60000000_70000000_80000000;
    write8(ops);

    // ABORT out of BUSY, then asynchronous reset while BUSY.
    to_hw_sig = CMD_ABORT;
    tick();
    check("abort_busy_io", {127'd0, io_ready}, 128'd0);
    check("abort_keep_msg", msg_en, 128'h10000000_20000000_30000000_40000000);
    to_hw_sig = CMD_IDLE;
    tick();
    ops = 256'h0a0a0a0a_0b0b0b0b_0c0c0c0c_0d0d0d0d_0e0e0e0e_0f0f0f0f_01010101_02020202;
    write8(ops);
    tick();
    #3;
    reset_n = 1'b0;
    #1;
    check("arst_io", {127'd0, io_ready}, 128'd0);
    check("arst_msg", msg_en, 128'd0);
    check("arst_key", key, 128'd0);
    check("arst_sig", {126'd0, to_sw_sig}, 128'd0);
    check("arst_port", {96'd0, to_sw_port}, 128'd0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();

    // aes_ready already high when BUSY is entered.
    ops = 256'h0f0e0d0c_0b0a0908_07060504_03020100_f0e0d0c0_b0a09080_70605040_30201000;
    for (int i = 0; i < 7; i++) wr_word(ops[255-32*i -: 32]);
    to_hw_sig  = CMD_WRITE;
    to_hw_port = ops[31:0];
    tick();
    res       = 128'h76543210_fedcba98_13579bdf_2468ace0;
    msg_de    = res;
    aes_ready = 1'b1;
    to_hw_sig = CMD_IDLE;
    tick();
    check("early_io", {127'd0, io_ready}, 128'd1);
    check("early_sig0", {126'd0, to_sw_sig}, 128'd0);
    push_result(res);
    tick();
    aes_ready = 1'b0;
    msg_de    = '0;
    check("early_rr", {126'd0, to_sw_sig}, {126'd0, STS_RESULT_READY});
    check("early_io_fall", {127'd0, io_ready}, 128'd0);
    read4();
    check("sb_drained", 128'(sb.size()), 128'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
